// File: rtl/dm_4k.sv
// 2^ADDR_W x DATA_W data memory: asynchronous read, synchronous write, synchronous clear.
// Optional per-byte write enables are built in when DM_4K_BYTE_WRITE_EN is defined.
module dm_4k #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                we,
  input  logic                clk,
  output logic [DATA_W-1:0]   dout,
  input  logic                rst
`ifdef DM_4K_BYTE_WRITE_EN
  ,
  input  logic [DATA_W/8-1:0] be
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wr_word_d;

  // Merged write word. Disabled byte lanes keep the stored value.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves wr_word_d unassigned and infers a latch.
    wr_word_d = din;
`ifdef DM_4K_BYTE_WRITE_EN
    wr_word_d = mem_q[addr];
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) wr_word_d[8*i +: 8] = din[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: storage arrays are usually left unreset. This one is cleared because every word must read 0 after reset.
    // Non-blocking assignments keep the reads above seeing the pre-edge contents.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wr_word_d;
    end
  end

  // Read has no latency. During a write cycle dout shows the old word, and din is never bypassed to dout.
  assign dout = mem_q[addr];

endmodule

// File: tb/tb_dm_4k.sv
// Self-checking bench for dm_4k. Every read pushes its expected word to a scoreboard queue.
// The word is popped and compared when dout is sampled.
module tb_dm_4k;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] din  = '0;
  logic [31:0] dout;
  logic [3:0]  be   = 4'hF;

  logic [31:0] model_mem [1024];
  sb_entry_t   sb_q [$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  dm_4k #(.ADDR_W(10), .DATA_W(32)) dut (
    .addr (addr),
    .din  (din),
    .we   (we),
    .clk  (clk),
    .dout (dout),
    .rst  (rst)
`ifdef DM_4K_BYTE_WRITE_EN
    ,
    .be   (be)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = new_w;
`ifdef DM_4K_BYTE_WRITE_EN
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic pop_and_check();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $error("FAIL scoreboard_empty: observed 0x%08h expected <entry>", dout);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, dout, e.exp);
    end
  endtask

  task automatic do_reset(input logic with_write, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b1; we = with_write; addr = a; din = d; be = 4'hF;
    @(posedge clk);
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a; din = d; we = 1'b1; be = m;
    @(posedge clk);
    model_mem[a] = merge(model_mem[a], d, m);
  endtask

  task automatic do_read(input string tag, input logic [9:0] a, input logic [31:0] exp);
    sb_entry_t e;
    @(negedge clk);
    we = 1'b0; addr = a;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
    #1;
    pop_and_check();
  endtask

  initial begin
    logic [9:0]  ra [16];
    logic [31:0] rd;
    sb_entry_t   e;

    do_reset(1'b0, 10'd0, 32'd0);
    do_read("reset_addr1", 10'd1, 32'h0);
    do_read("reset_addr2", 10'd2, 32'h0);

    do_write(10'd1, 32'h0000_0020, 4'hF);
    do_read("after_w1_addr2", 10'd2, 32'h0);
    do_read("after_w1_addr1", 10'd1, 32'h0000_0020);

    do_write(10'd2, 32'h0, 4'hF);
    do_read("no_alias_addr1", 10'd1, 32'h0000_0020);

    // Two writes back to back at the two address extremes.
    do_write(10'h3FF, 32'hDEAD_BEEF, 4'hF);
    do_write(10'h000, 32'h1234_5678, 4'hF);
    do_read("top_addr", 10'h3FF, 32'hDEAD_BEEF);
    do_read("bottom_addr", 10'h000, 32'h1234_5678);

    do_write(10'd9, 32'hAAAA_0001, 4'hF);
    do_write(10'd9, 32'hBBBB_0002, 4'hF);
    do_read("last_write_wins", 10'd9, 32'hBBBB_0002);

    // Read-during-write: before the edge, dout still shows the old word.
    @(negedge clk);
    addr = 10'd1; din = 32'h5555_5555; we = 1'b1; be = 4'hF;
    e.tag = "rdw_old_word"; e.exp = 32'h0000_0020;
    sb_q.push_back(e);
    #1;
    pop_and_check();
    @(posedge clk);
    model_mem[1] = 32'h5555_5555;
    #1;
    e.tag = "rdw_new_after_edge"; e.exp = 32'h5555_5555;
    sb_q.push_back(e);
    pop_and_check();

    // With we=0, a clock edge must not change anything.
    @(negedge clk);
    we = 1'b0; addr = 10'd1; din = 32'hFFFF_FFFF;
    @(posedge clk);
    do_read("we0_no_change", 10'd1, 32'h5555_5555);

    // Random writes, then read every written address back.
    for (int i = 0; i < 16; i++) begin
      ra[i] = 10'($urandom_range(16, 1000));
      rd    = $urandom;
      do_write(ra[i], rd, 4'hF);
    end
    for (int i = 0; i < 16; i++) do_read("random_readback", ra[i], model_mem[ra[i]]);
    do_read("untouched_addr", 10'd1001, 32'h0);

    // The same-cycle write is discarded because reset takes priority.
    do_write(10'd5, 32'hFFFF_FFFF, 4'hF);
    do_read("pre_reset_addr5", 10'd5, 32'hFFFF_FFFF);
    do_reset(1'b1, 10'd5, 32'hAAAA_AAAA);
    do_read("reset_prio_addr5", 10'd5, 32'h0);
    do_read("reset_clears_addr1", 10'd1, 32'h0);
    do_read("reset_clears_top", 10'h3FF, 32'h0);

`ifdef DM_4K_BYTE_WRITE_EN
    do_write(10'd7, 32'h1122_3344, 4'hF);
    do_write(10'd7, 32'hAABB_CCDD, 4'b0101);
    do_read("byte_en_0101", 10'd7, 32'h11BB_33DD);
    do_write(10'd7, 32'hFFFF_FFFF, 4'b0000);
    do_read("byte_en_none", 10'd7, 32'h11BB_33DD);
    do_write(10'd7, 32'h0000_0000, 4'b1000);
    do_read("byte_en_1000", 10'd7, 32'h00BB_33DD);
`else
    do_write(10'd7, 32'h1122_3344, 4'hF);
    do_write(10'd7, 32'hAABB_CCDD, 4'b0101);
    do_read("full_word_write", 10'd7, 32'hAABB_CCDD);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
